// File: rtl/fir_result_reader_pkg.sv
// fir_result_reader_pkg: shared FIR word sizes, normalization constants, reader FSM states
package fir_result_reader_pkg;
  localparam int INPUT_WORD_SIZE  = 8;
  localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + 8;
  localparam int ROUND            = 128;
  localparam int NORM_SHIFT       = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;
  // Round half up, then clamp anything that no longer fits the input word.
  function automatic logic [INPUT_WORD_SIZE-1:0] normalize(input logic [OUTPUT_WORD_SIZE-1:0] x);
    logic [OUTPUT_WORD_SIZE:0] s;
    logic [OUTPUT_WORD_SIZE-NORM_SHIFT:0] q;
    s = {1'b0, x} + (OUTPUT_WORD_SIZE+1)'(ROUND);
    q = s[OUTPUT_WORD_SIZE:NORM_SHIFT];
    return q[INPUT_WORD_SIZE] ? '1 : q[INPUT_WORD_SIZE-1:0];
  endfunction
endpackage

// File: rtl/fir_result_reader_if.sv
// fir_result_reader_if: ready/valid output stream of the result reader
interface fir_result_reader_if #(parameter int W = fir_result_reader_pkg::INPUT_WORD_SIZE);
  logic [W-1:0] m_data_out;
  logic         m_valid_out;
  logic         m_ready_in;
  modport master (output m_data_out, output m_valid_out, input m_ready_in);
  modport slave  (input m_data_out, input m_valid_out, output m_ready_in);
endinterface

// File: rtl/fir_result_reader_fifo.sv
// fir_sync_fifo: first-word-fall-through FIFO with occupancy and sticky drop flag
module fir_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_rd,
  output logic [W-1:0]             o_rdata,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          w_pop, w_push, w_full;
  // A pop frees the slot in the same edge, so a full FIFO still accepts the write.
  assign w_pop      = i_rd && (r_level != '0);
  assign w_full     = r_level == (AW+1)'(DEPTH);
  assign w_push     = i_wr && (!w_full || w_pop);
  assign o_valid    = r_level != '0;
  assign o_rdata    = o_valid ? r_mem[r_rptr] : '0;
  assign o_level    = r_level;
  assign o_overflow = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= r_ovf | (i_wr && !w_push);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/fir_result_reader.sv
// fir_result_reader: discards filter settling outputs, decimates, normalizes and buffers FIR results
module fir_result_reader import fir_result_reader_pkg::*; #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SETTLE     = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          en_in,
  input  logic [OUTPUT_WORD_SIZE-1:0]   fir_data_in,
  fir_result_reader_if.master           m_if,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int PW = $clog2(DECIM + 1);
  state_t                     r_state, w_next;
  logic [SW-1:0]              r_cnt;
  logic [PW-1:0]              r_phase;
  logic                       r_wr;
  logic [INPUT_WORD_SIZE-1:0] r_wdata;
  logic                       w_keep;
  // The enabling IDLE cycle is the first discarded output, so SETTLE spans SETTLE-1 cycles.
  always_comb begin
    w_next = r_state;
    if (!en_in) w_next = ST_IDLE;
    else if (r_state == ST_IDLE) w_next = (SETTLE <= 1) ? ST_RUN : ST_SETTLE;
    else if (r_state == ST_SETTLE && r_cnt == SW'(SETTLE - 2)) w_next = ST_RUN;
  end
  assign w_keep = en_in && (r_state == ST_RUN) && (r_phase == '0);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr    <= w_keep;
    end
    r_wdata <= normalize(fir_data_in);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in || w_next == ST_IDLE) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else begin
      r_cnt   <= (r_state == ST_SETTLE) ? r_cnt + SW'(1) : r_cnt;
      r_phase <= (r_state != ST_RUN || r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
    end
  end
  fir_sync_fifo #(.W(INPUT_WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .i_wr       (r_wr),
    .i_wdata    (r_wdata),
    .i_rd       (m_if.m_ready_in),
    .o_rdata    (m_if.m_data_out),
    .o_valid    (m_if.m_valid_out),
    .o_level    (level_out),
    .o_overflow (overflow_out)
  );
endmodule

// File: tb/tb_fir_result_reader.sv
// tb_fir_result_reader: directed scenarios for settle, decimation, rounding, overflow and reset
module tb_fir_result_reader;
  import fir_result_reader_pkg::*;
  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b0;
  logic                        en_in = 1'b0;
  logic [OUTPUT_WORD_SIZE-1:0] fir_data_in = '0;
  logic                        overflow_out;
  logic [3:0]                  level_out;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  bit ramp = 1'b0;

  always #5 clk_in = ~clk_in;

  fir_result_reader_if m_if();

  fir_result_reader dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .en_in        (en_in),
    .fir_data_in  (fir_data_in),
    .m_if         (m_if),
    .overflow_out (overflow_out),
    .level_out    (level_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (ramp) fir_data_in = OUTPUT_WORD_SIZE'(cyc * 256);
  endtask

  // Resets, then leaves the bench in cycle 0 of a fresh enable.
  task automatic start_run(input bit rmp, input bit rdy);
    rst_in = 1'b1;
    en_in = 1'b0;
    m_if.m_ready_in = rdy;
    ramp = rmp;
    fir_data_in = '0;
    step();
    rst_in = 1'b0;
    en_in = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    en_in = 1'b0;
    m_if.m_ready_in = 1'b0;
    fir_data_in = 16'h1234;
    step();
    rst_in = 1'b0;
    total++; if (level_out !== 4'd0) $display("FAIL reset_level: got %0d want 0", level_out); else passed++;
    total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_if.m_valid_out); else passed++;
    total++; if (m_if.m_data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", m_if.m_data_out); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_out); else passed++;
    total++; if (dut.r_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_IDLE); else passed++;
  endtask

  task automatic test_settle();
    start_run(1'b0, 1'b0);
    fir_data_in = 16'h1234;
    repeat (9) begin
      step();
      total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL settle_quiet: cycle %0d valid %b want 0", cyc, m_if.m_valid_out); else passed++;
    end
    step();
    total++; if ({m_if.m_valid_out, m_if.m_data_out} !== 9'h112) $display("FAIL settle_first: cycle %0d valid %b data %h want 1/12", cyc, m_if.m_valid_out, m_if.m_data_out); else passed++;
    total++; if (level_out !== 4'd1) $display("FAIL settle_level: got %0d want 1", level_out); else passed++;
  endtask

  task automatic test_ramp();
    logic [7:0] got[$];
    start_run(1'b1, 1'b1);
    repeat (32) begin
      step();
      if (m_if.m_valid_out) got.push_back(m_if.m_data_out);
    end
    total++; if (got.size() != 6) $display("FAIL ramp_count: got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== 8'(8 + 4 * i)) $display("FAIL ramp_value[%0d]: got %0d want %0d", i, got[i], 8 + 4 * i); else passed++;
    end
  endtask

  task automatic test_rounding(input logic [15:0] val, input logic [7:0] exp_q);
    start_run(1'b0, 1'b1);
    fir_data_in = val;
    repeat (10) step();
    total++; if ({m_if.m_valid_out, m_if.m_data_out} !== {1'b1, exp_q}) $display("FAIL rounding_%h: valid %b data %h want 1/%h", val, m_if.m_valid_out, m_if.m_data_out, exp_q); else passed++;
  endtask

  task automatic test_overflow();
    start_run(1'b1, 1'b0);
    repeat (41) step();
    total++; if (level_out !== 4'd8) $display("FAIL ovf_full_level: got %0d want 8", level_out); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL ovf_before: got %b want 0", overflow_out); else passed++;
    step();
    total++; if (overflow_out !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_out); else passed++;
    total++; if (level_out !== 4'd8) $display("FAIL ovf_level_hold: got %0d want 8", level_out); else passed++;
    repeat (6) step();
    en_in = 1'b0;
    ramp = 1'b0;
    step();
    step();
    m_if.m_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if ({m_if.m_valid_out, m_if.m_data_out} !== {1'b1, 8'(8 + 4 * i)}) $display("FAIL ovf_drain[%0d]: valid %b data %0d want 1/%0d", i, m_if.m_valid_out, m_if.m_data_out, 8 + 4 * i); else passed++;
      step();
    end
    total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL ovf_empty: valid %b want 0", m_if.m_valid_out); else passed++;
    total++; if (overflow_out !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_out); else passed++;
  endtask

  task automatic test_full_pop();
    start_run(1'b1, 1'b0);
    repeat (41) step();
    m_if.m_ready_in = 1'b1;
    step();
    m_if.m_ready_in = 1'b0;
    total++; if (level_out !== 4'd8) $display("FAIL fullpop_level: got %0d want 8", level_out); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL fullpop_overflow: got %b want 0", overflow_out); else passed++;
    en_in = 1'b0;
    ramp = 1'b0;
    m_if.m_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if ({m_if.m_valid_out, m_if.m_data_out} !== {1'b1, 8'(12 + 4 * i)}) $display("FAIL fullpop_drain[%0d]: valid %b data %0d want 1/%0d", i, m_if.m_valid_out, m_if.m_data_out, 12 + 4 * i); else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    start_run(1'b1, 1'b0);
    repeat (27) step();
    total++; if (level_out !== 4'd5) $display("FAIL mid_level_before: got %0d want 5", level_out); else passed++;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    total++; if (level_out !== 4'd0) $display("FAIL mid_level_after: got %0d want 0", level_out); else passed++;
    total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL mid_valid_after: got %b want 0", m_if.m_valid_out); else passed++;
    total++; if (dut.r_state !== ST_IDLE) $display("FAIL mid_state: got %0d want %0d", dut.r_state, ST_IDLE); else passed++;
    repeat (9) step();
    total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL mid_resettle_quiet: got %b want 0", m_if.m_valid_out); else passed++;
    step();
    total++; if ({m_if.m_valid_out, m_if.m_data_out} !== {1'b1, 8'd36}) $display("FAIL mid_resettle_first: valid %b data %0d want 1/36", m_if.m_valid_out, m_if.m_data_out); else passed++;
  endtask

  task automatic test_reenable();
    start_run(1'b1, 1'b1);
    repeat (20) step();
    en_in = 1'b0;
    step();
    total++; if (dut.r_state !== ST_IDLE) $display("FAIL reen_state: got %0d want %0d", dut.r_state, ST_IDLE); else passed++;
    en_in = 1'b1;
    repeat (9) begin
      step();
      total++; if (m_if.m_valid_out !== 1'b0) $display("FAIL reen_quiet: cycle %0d valid %b want 0", cyc, m_if.m_valid_out); else passed++;
    end
    step();
    total++; if ({m_if.m_valid_out, m_if.m_data_out} !== {1'b1, 8'd29}) $display("FAIL reen_first: valid %b data %0d want 1/29", m_if.m_valid_out, m_if.m_data_out); else passed++;
  endtask

  initial begin
    m_if.m_ready_in = 1'b0;
    test_reset();
    test_settle();
    test_ramp();
    test_rounding(16'h017F, 8'h01);
    test_rounding(16'h0180, 8'h02);
    test_rounding(16'hFF80, 8'hFF);
    test_rounding(16'hFFFF, 8'hFF);
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_reenable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_result_reader.md
FIR_RESULT_READER -- requirements
Module: fir_result_reader

Interface
REQ-001 Parameter DECIM, default 4: keep one of every DECIM filter outputs (legal range 1..16).
REQ-002 Parameter FIFO_DEPTH, default 8: output FIFO entries (power of two, 2..64).
REQ-003 Parameter SETTLE, default 8: filter outputs discarded after enable, equal to the filter order.
REQ-004 The block SHALL use one clock, clk_in; reset rst_in is synchronous and active-high.
REQ-005 clk_in  in  1  rising-edge clock shared with the filter.
REQ-006 rst_in  in  1  synchronous active-high reset.
REQ-007 en_in  in  1  capture enable; high = filter output is meaningful every cycle.
REQ-008 fir_data_in  in  OUTPUT_WORD_SIZE  unsigned filter output, one sample per clk_in.
REQ-009 m_data_out  out  INPUT_WORD_SIZE  normalized, decimated sample at FIFO head.
REQ-010 m_valid_out  out  1  m_data_out holds a sample.
REQ-011 m_ready_in  in  1  downstream accepts; transfer when m_valid_out && m_ready_in.
REQ-012 overflow_out  out  1  sticky: a kept sample was dropped on a full FIFO.
REQ-013 level_out  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-014 FSM states: IDLE, SETTLE, RUN.
REQ-015 Transitions: IDLE->SETTLE on en_in=1; SETTLE->RUN after SETTLE enabled cycles; any state->IDLE on en_in=0.
REQ-016 Settle and decimation counters clear when entering IDLE, so re-enable always restarts settling.
REQ-017 In RUN, the phase counter counts 0..DECIM-1 and wraps; the sample is kept when phase=0, so the first RUN cycle is kept.
REQ-018 Normalization: (fir_data_in + 128) >> 8, rounding half up; if the result exceeds 2^INPUT_WORD_SIZE-1, saturate to 2^INPUT_WORD_SIZE-1.
REQ-019 Pipeline: the kept sample is registered together with a write strobe in the cycle after capture; the FIFO write occurs on the next edge.
REQ-020 A sample present on fir_data_in in cycle t is visible at the FIFO head (empty FIFO) with m_valid_out=1 in cycle t+2.
REQ-021 FIFO is first-word-fall-through; m_valid_out = (level_out != 0).
REQ-022 m_data_out SHALL stay stable while m_valid_out && !m_ready_in.
REQ-023 Write on a full FIFO without a simultaneous pop: the sample is dropped, FIFO contents are unchanged, and overflow_out is set.
REQ-024 Write and pop in the same cycle on a full FIFO: both succeed and level_out is unchanged.
REQ-025 Write and pop in the same cycle on an empty FIFO: no pop occurs (nothing valid); the write succeeds and level_out becomes 1.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 overflow_out clears only on rst_in.
REQ-028 en_in=0 does not flush the FIFO. An in-flight pipeline sample is still written.

Reset
REQ-029 With rst_in=1 at a clock edge: FSM=IDLE, all counters=0, pointers=0, level_out=0, m_valid_out=0, overflow_out=0, pipeline write strobe=0.
REQ-030 After reset: m_data_out=0; the FIFO storage array is not reset.
REQ-031 Reset mid-operation discards all FIFO contents and in-flight samples within the same edge.

Structure
REQ-032 OUTPUT_WORD_SIZE (= INPUT_WORD_SIZE+8), the rounding constant 128, the normalization shift 8 and the FSM state enum SHALL live in the shared fir parameter package next to INPUT_WORD_SIZE.
REQ-033 The FIFO SHALL be one sub-module, fir_sync_fifo, parameterized by width and depth and exposing level.
REQ-034 fir_result_reader holds the FSM, counters and normalization stage only.

Verification (INPUT_WORD_SIZE=8, defaults)
REQ-035 Reset then en_in=1, constant fir_data_in=0x1234: the first 8 cycles produce no write; the first kept sample is m_data_out=0x12, with m_valid_out rising 10 cycles after en_in.
REQ-036 Ramp fir_data_in=k*256 with m_ready_in=1: outputs are k=8,12,16,...
REQ-037 Rounding: 0x017F -> 0x01; 0x0180 -> 0x02; 0xFF80 -> 0xFF (saturation path, 0xFFFF -> 0xFF).
REQ-038 m_ready_in=0 for 40 RUN cycles: level_out reaches 8; the 9th kept sample sets overflow_out; popping then returns the first 8 samples in order.
REQ-039 Full FIFO with m_ready_in=1 exactly on a keep cycle: level_out stays 8 and overflow_out stays 0.
REQ-040 rst_in pulsed with level_out=5: the next cycle shows level_out=0, m_valid_out=0 and FSM=IDLE. Dropping en_in for 1 cycle restarts the 8-cycle settle.
